// File: rtl/wb_cache_dm_pkg.sv
// Shared types and width helpers for the direct-mapped write-back cache.
package wb_cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WRITEBACK,
      ALLOCATE,
      FLUSH
   } state_e;

   // Word-offset field width within a line.
   function automatic int unsigned off_width(input int unsigned words_per_line);
      return $clog2(words_per_line);
   endfunction

   // Line-index field width.
   function automatic int unsigned idx_width(input int unsigned lines);
      return $clog2(lines);
   endfunction

   // Tag field width: what remains of the word address after index and offset.
   function automatic int unsigned tag_width(input int unsigned addr_w,
                                             input int unsigned words_per_line,
                                             input int unsigned lines);
      return addr_w - $clog2(lines) - $clog2(words_per_line);
   endfunction

endpackage

// File: rtl/wb_cache_dm_if.sv
// CPU-side word port, memory-side line port and flush handshake of the cache.
// slave: the cache's view; master: the view of the CPU/memory environment.
interface wb_cache_dm_if #(
   parameter int unsigned ADDR_W         = 10,
   parameter int unsigned WORD_W         = 10,
   parameter int unsigned WORDS_PER_LINE = 2
);
   import wb_cache_pkg::*;

   localparam int unsigned OFF_W  = off_width(WORDS_PER_LINE);
   localparam int unsigned LINE_W = WORD_W * WORDS_PER_LINE;

   logic                     cpu_req;
   logic                     cpu_we;
   logic [ADDR_W-1:0]        cpu_addr;
   logic [WORD_W-1:0]        cpu_wdata;
   logic [WORD_W-1:0]        cpu_rdata;
   logic                     cpu_ready;
   logic                     flush_req;
   logic                     flush_done;
   logic                     mem_req;
   logic                     mem_we;
   logic [ADDR_W-OFF_W-1:0]  mem_addr;
   logic [LINE_W-1:0]        mem_wdata;
   logic [LINE_W-1:0]        mem_rdata;
   logic                     mem_ready;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush_req, mem_rdata, mem_ready,
      output cpu_rdata, cpu_ready, flush_done, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush_req, mem_rdata, mem_ready,
      input  cpu_rdata, cpu_ready, flush_done, mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/wb_cache_dm_store.sv
// Tag/valid/dirty/data arrays: asynchronous read at one index, synchronous
// word write or line fill, asynchronous clear of valid and dirty on reset.
module wb_cache_store
   import wb_cache_pkg::*;
#(
   parameter int unsigned WORD_W         = 10,
   parameter int unsigned WORDS_PER_LINE = 2,
   parameter int unsigned LINES          = 16,
   parameter int unsigned TAG_W          = 5
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [idx_width(LINES)-1:0]             idx_i,
   output logic                                    rd_valid_o,
   output logic                                    rd_dirty_o,
   output logic [TAG_W-1:0]                        rd_tag_o,
   output logic [WORDS_PER_LINE-1:0][WORD_W-1:0]   rd_line_o,
   input  logic                                    wr_word_i,
   input  logic [off_width(WORDS_PER_LINE)-1:0]    wr_off_i,
   input  logic [WORD_W-1:0]                       wr_data_i,
   input  logic                                    fill_i,
   input  logic [TAG_W-1:0]                        fill_tag_i,
   input  logic [WORDS_PER_LINE-1:0][WORD_W-1:0]   fill_line_i,
   input  logic                                    clean_i
);

   logic [LINES-1:0]                       valid_q;
   logic [LINES-1:0]                       dirty_q;
   logic [TAG_W-1:0]                       tag_q  [LINES];
   logic [WORDS_PER_LINE-1:0][WORD_W-1:0]  data_q [LINES];

   // Line state bits; a fill wins over a word write or a clean at the same index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_i) begin
         valid_q[idx_i] <= 1'b1;
         dirty_q[idx_i] <= 1'b0;
      end else if (wr_word_i) begin
         dirty_q[idx_i] <= 1'b1;
      end else if (clean_i) begin
         dirty_q[idx_i] <= 1'b0;
      end
   end

   // Tag and data storage, deliberately left unreset.
   always_ff @(posedge clk) begin
      if (fill_i) begin
         tag_q[idx_i]  <= fill_tag_i;
         data_q[idx_i] <= fill_line_i;
      end else if (wr_word_i) begin
         data_q[idx_i][wr_off_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[idx_i];
   assign rd_dirty_o = dirty_q[idx_i];
   assign rd_tag_o   = tag_q[idx_i];
   assign rd_line_o  = data_q[idx_i];

endmodule

// File: rtl/wb_cache_dm.sv
// Direct-mapped, write-back, write-allocate cache with full-cache flush.
// Holds the controller FSM, the CPU request latch and the flush pointer.
module wb_cache_dm
   import wb_cache_pkg::*;
#(
   parameter int unsigned ADDR_W         = 10,
   parameter int unsigned WORD_W         = 10,
   parameter int unsigned WORDS_PER_LINE = 2,
   parameter int unsigned LINES          = 16
) (
   input  logic         clk,
   input  logic         rst,
   wb_cache_dm_if.slave bus
);

   localparam int unsigned OFF_W = off_width(WORDS_PER_LINE);
   localparam int unsigned IDX_W = idx_width(LINES);
   localparam int unsigned TAG_W = tag_width(ADDR_W, WORDS_PER_LINE, LINES);

   typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

   state_e                    state_q;
   logic [IDX_W-1:0]          ptr_q;
   logic [ADDR_W-1:0]         req_addr_q;
   logic                      req_we_q;
   logic [WORD_W-1:0]         req_wdata_q;
   logic                      cpu_ready_q;
   logic [WORD_W-1:0]         cpu_rdata_q;
   logic                      flush_done_q;
   logic                      mem_req_q;
   logic                      mem_we_q;
   logic [ADDR_W-OFF_W-1:0]   mem_addr_q;
   line_t                     mem_wdata_q;

   logic [TAG_W-1:0]          req_tag;
   logic [IDX_W-1:0]          req_idx;
   logic [OFF_W-1:0]          req_off;
   logic [IDX_W-1:0]          st_idx;
   logic                      rd_valid;
   logic                      rd_dirty;
   logic [TAG_W-1:0]          rd_tag;
   line_t                     rd_line;
   logic                      hit;
   logic                      mem_done;
   logic                      wr_word;
   logic                      fill;
   logic                      clean;

   assign req_tag  = req_addr_q[ADDR_W-1 -: TAG_W];
   assign req_idx  = req_addr_q[OFF_W +: IDX_W];
   assign req_off  = req_addr_q[OFF_W-1:0];
   assign st_idx   = (state_q == FLUSH) ? ptr_q : req_idx;
   assign hit      = rd_valid && (rd_tag == req_tag);
   assign mem_done = mem_req_q && bus.mem_ready;

   // Array write strobes, decoded from the current state and handshake.
   always_comb begin
      wr_word = (state_q == LOOKUP) && hit && req_we_q;
      fill    = (state_q == ALLOCATE) && mem_done;
      clean   = ((state_q == WRITEBACK) || (state_q == FLUSH)) && mem_done;
   end

   wb_cache_store #(
      .WORD_W         (WORD_W),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .LINES          (LINES),
      .TAG_W          (TAG_W)
   ) u_store (
      .clk         (clk),
      .rst         (rst),
      .idx_i       (st_idx),
      .rd_valid_o  (rd_valid),
      .rd_dirty_o  (rd_dirty),
      .rd_tag_o    (rd_tag),
      .rd_line_o   (rd_line),
      .wr_word_i   (wr_word),
      .wr_off_i    (req_off),
      .wr_data_i   (req_wdata_q),
      .fill_i      (fill),
      .fill_tag_i  (req_tag),
      .fill_line_i (bus.mem_rdata),
      .clean_i     (clean)
   );

   // Controller FSM; memory transactions are issued one cycle after entering
   // WRITEBACK/ALLOCATE (or after each flush write), which yields the one-cycle
   // mem_req gap after every accepted transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         req_addr_q   <= '0;
         req_we_q     <= 1'b0;
         req_wdata_q  <= '0;
         cpu_ready_q  <= 1'b0;
         cpu_rdata_q  <= '0;
         flush_done_q <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         cpu_ready_q  <= 1'b0;
         flush_done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.flush_req) begin
                  ptr_q   <= '0;
                  state_q <= FLUSH;
               end else if (bus.cpu_req) begin
                  req_addr_q  <= bus.cpu_addr;
                  req_we_q    <= bus.cpu_we;
                  req_wdata_q <= bus.cpu_wdata;
                  state_q     <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  cpu_ready_q <= 1'b1;
                  cpu_rdata_q <= req_we_q ? req_wdata_q : rd_line[req_off];
                  state_q     <= IDLE;
               end else if (rd_valid && rd_dirty) begin
                  state_q <= WRITEBACK;
               end else begin
                  state_q <= ALLOCATE;
               end
            end
            WRITEBACK: begin
               if (!mem_req_q) begin
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= {rd_tag, req_idx};
                  mem_wdata_q <= rd_line;
               end else if (bus.mem_ready) begin
                  mem_req_q <= 1'b0;
                  state_q   <= ALLOCATE;
               end
            end
            ALLOCATE: begin
               if (!mem_req_q) begin
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= {req_tag, req_idx};
               end else if (bus.mem_ready) begin
                  mem_req_q <= 1'b0;
                  state_q   <= LOOKUP;
               end
            end
            FLUSH: begin
               if (mem_req_q) begin
                  if (bus.mem_ready) begin
                     mem_req_q <= 1'b0;
                     if (&ptr_q) begin
                        flush_done_q <= 1'b1;
                        ptr_q        <= '0;
                        state_q      <= IDLE;
                     end else begin
                        ptr_q <= ptr_q + 1'b1;
                     end
                  end
               end else if (rd_valid && rd_dirty) begin
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= {rd_tag, ptr_q};
                  mem_wdata_q <= rd_line;
               end else if (&ptr_q) begin
                  flush_done_q <= 1'b1;
                  ptr_q        <= '0;
                  state_q      <= IDLE;
               end else begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.cpu_ready  = cpu_ready_q;
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.flush_done = flush_done_q;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_wb_cache_dm.sv
// Scoreboard bench for wb_cache_dm with default parameters: directed CPU and
// flush traffic against a simple line memory with programmable latency/stall.
module tb_wb_cache_dm;

   localparam int K_MEM   = 0;
   localparam int K_CPU   = 1;
   localparam int K_FLUSH = 2;

   typedef struct {
      int          kind;
      logic        we;
      int unsigned addr;
      int unsigned data;
      int          gap;
   } ev_t;

   logic        clk;
   logic        rst;
   logic        stall;
   int          lat;
   int          checks;
   int          errors;
   int          cyc;
   ev_t         expq[$];
   logic [19:0] mem [512];

   wb_cache_dm_if #(.ADDR_W(10), .WORD_W(10), .WORDS_PER_LINE(2)) bus ();

   wb_cache_dm #(
      .ADDR_W         (10),
      .WORD_W         (10),
      .WORDS_PER_LINE (2),
      .LINES          (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic exp_mem(input logic we, input int unsigned addr, input int unsigned data, input int gap);
      ev_t e;
      e.kind = K_MEM; e.we = we; e.addr = addr; e.data = data; e.gap = gap;
      expq.push_back(e);
   endtask

   task automatic exp_cpu(input int unsigned data);
      ev_t e;
      e.kind = K_CPU; e.we = 1'b0; e.addr = 0; e.data = data; e.gap = -1;
      expq.push_back(e);
   endtask

   task automatic exp_flush();
      ev_t e;
      e.kind = K_FLUSH; e.we = 1'b0; e.addr = 0; e.data = 0; e.gap = -1;
      expq.push_back(e);
   endtask

   task automatic start_req(input logic we, input logic [9:0] addr, input logic [9:0] wdata);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.cpu_ready && n < 300);
      if (!bus.cpu_ready) begin
         checks++;
         errors++;
         $display("FAIL cpu_ready_timeout: got no cpu_ready, required within 300 cycles");
      end
      bus.cpu_req = 1'b0;
   endtask

   task automatic cpu_access(input logic we, input logic [9:0] addr, input logic [9:0] wdata, output int n);
      start_req(we, addr, wdata);
      wait_ready(n);
   endtask

   task automatic wait_memreq();
      int n = 0;
      while (!bus.mem_req && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("mem_req_seen", bus.mem_req, 1);
   endtask

   task automatic do_flush(output int n);
      bus.flush_req = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         bus.flush_req = 1'b0;
         n++;
      end while (!bus.flush_done && n < 600);
      if (!bus.flush_done) begin
         checks++;
         errors++;
         $display("FAIL flush_timeout: got no flush_done, required within 600 cycles");
      end
   endtask

   // Line memory: answers mem_req after lat cycles unless stalled.
   initial begin
      int cnt = 0;
      for (int a = 0; a < 512; a++) mem[a] = {10'(3 * a + 1), 10'(3 * a)};
      mem[25] = {10'd7, 10'd5};
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.mem_ready = 1'b0;
            cnt = 0;
         end else if (bus.mem_ready) begin
            bus.mem_ready = 1'b0;
         end else if (bus.mem_req && !stall) begin
            if (cnt == lat) begin
               cnt = 0;
               bus.mem_ready = 1'b1;
               if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
               else            bus.mem_rdata = mem[bus.mem_addr];
            end else begin
               cnt++;
            end
         end
      end
   end

   // Monitor: every DUT output event pops the next expectation and compares.
   initial begin
      logic prev_req = 1'b0;
      int   low_cnt  = 0;
      ev_t  e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_req = 1'b0;
            low_cnt  = 0;
         end else begin
            if ((bus.mem_req && !prev_req) || bus.cpu_ready || bus.flush_done) begin
               if (expq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_event: got req=%0d ready=%0d done=%0d, required none",
                           bus.mem_req, bus.cpu_ready, bus.flush_done);
               end else begin
                  e = expq.pop_front();
                  if (bus.mem_req && !prev_req) begin
                     chk("event_kind_mem", K_MEM, e.kind);
                     if (e.kind == K_MEM) begin
                        chk("mem_we", bus.mem_we, e.we);
                        chk("mem_addr", bus.mem_addr, e.addr);
                        if (e.we) chk("mem_wdata", bus.mem_wdata, e.data);
                        if (e.gap >= 0) chk("mem_req_gap", low_cnt, e.gap);
                     end
                  end else if (bus.cpu_ready) begin
                     chk("event_kind_cpu", K_CPU, e.kind);
                     if (e.kind == K_CPU) chk("cpu_rdata", bus.cpu_rdata, e.data);
                  end else begin
                     chk("event_kind_flush", K_FLUSH, e.kind);
                  end
               end
            end
            if (bus.mem_req) low_cnt = 0;
            else             low_cnt++;
            prev_req = bus.mem_req;
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      stall  = 1'b0;
      lat    = 3;
      rst    = 1'b1;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.flush_req = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_cpu_ready",  bus.cpu_ready, 0);
      chk("rst_cpu_rdata",  bus.cpu_rdata, 0);
      chk("rst_flush_done", bus.flush_done, 0);
      chk("rst_mem_req",    bus.mem_req, 0);
      chk("rst_mem_we",     bus.mem_we, 0);
      chk("rst_mem_addr",   bus.mem_addr, 0);
      chk("rst_mem_wdata",  bus.mem_wdata, 0);

      // Read miss at 50 (line 25), then the other word as a hit.
      exp_mem(1'b0, 25, 0, -1); exp_cpu(5);
      cpu_access(1'b0, 10'd50, 10'd0, cyc);
      chk("clean_miss_latency", cyc, 8);
      exp_cpu(7);
      cpu_access(1'b0, 10'd51, 10'd0, cyc);
      chk("hit_latency_51", cyc, 2);

      // Write miss at 84 (index 10, tag 2), then read it back.
      exp_mem(1'b0, 42, 0, -1); exp_cpu(300);
      cpu_access(1'b1, 10'd84, 10'd300, cyc);
      exp_cpu(300);
      cpu_access(1'b0, 10'd84, 10'd0, cyc);
      chk("hit_latency_84", cyc, 2);

      // Dirty eviction: read 116 (index 10, tag 3).
      exp_mem(1'b1, 42, {10'd127, 10'd300}, -1);
      exp_mem(1'b0, 58, 0, 1);
      exp_cpu(174);
      cpu_access(1'b0, 10'd116, 10'd0, cyc);

      // Dirty lines 9 and 3, then flush twice.
      exp_cpu(11);
      cpu_access(1'b1, 10'd51, 10'd11, cyc);
      chk("write_hit_latency", cyc, 2);
      exp_mem(1'b0, 3, 0, -1); exp_cpu(99);
      cpu_access(1'b1, 10'd6, 10'd99, cyc);
      exp_mem(1'b1, 3, {10'd10, 10'd99}, -1);
      exp_mem(1'b1, 25, {10'd11, 10'd5}, -1);
      exp_flush();
      do_flush(cyc);
      exp_flush();
      do_flush(cyc);
      chk("clean_flush_latency", cyc, 17);

      // Memory stall on a read miss at 200 (line 100).
      exp_mem(1'b0, 100, 0, -1); exp_cpu(300);
      stall = 1'b1;
      start_req(1'b0, 10'd200, 10'd0);
      wait_memreq();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("stall_mem_req",   bus.mem_req, 1);
         chk("stall_mem_we",    bus.mem_we, 0);
         chk("stall_mem_addr",  bus.mem_addr, 100);
         chk("stall_cpu_ready", bus.cpu_ready, 0);
      end
      stall = 1'b0;
      wait_ready(cyc);

      // Reset while a write-back is outstanding.
      exp_mem(1'b0, 42, 0, -1); exp_cpu(55);
      cpu_access(1'b1, 10'd84, 10'd55, cyc);
      exp_mem(1'b1, 42, {10'd127, 10'd55}, -1);
      stall = 1'b1;
      start_req(1'b0, 10'd116, 10'd0);
      wait_memreq();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wb_stall_mem_addr",  bus.mem_addr, 42);
         chk("wb_stall_mem_wdata", bus.mem_wdata, {10'd127, 10'd55});
      end
      #2 rst = 1'b1;
      #1;
      chk("async_rst_mem_req",   bus.mem_req, 0);
      chk("async_rst_cpu_ready", bus.cpu_ready, 0);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      rst   = 1'b0;
      stall = 1'b0;
      exp_mem(1'b0, 42, 0, -1); exp_cpu(300);
      cpu_access(1'b0, 10'd84, 10'd0, cyc);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_cache_dm.md
# wb_cache_dm

Parametrised direct-mapped, write-back, write-allocate cache. It sits between a CPU-side word port and a line-wide memory port, and uses separate unidirectional data buses with no tri-states. Miss address and data are latched internally. The block adds a full-cache flush and a valid/ready handshake on both sides. It is the next-generation replacement for the fixed 16-line, 2-word, 10-bit cache.

## Interface
- ADDR_W, 10, CPU word-address width.
- WORD_W, 10, data word width.
- WORDS_PER_LINE, 2, words per line (power of two, ≥2).
- LINES, 16, number of lines (power of two, ≥2).
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- cpu_req  in  1  request; held with addr/we/wdata until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  WORD_W  write data.
- cpu_rdata  out  WORD_W  read data; valid only while cpu_ready is high.
- cpu_ready  out  1  one-cycle completion pulse.
- flush_req  in  1  request write-back of all dirty lines.
- flush_done  out  1  one-cycle flush completion pulse.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = line write, 0 = line read.
- mem_addr  out  ADDR_W-OFF_W  line address.
- mem_wdata  out  WORD_W*WORDS_PER_LINE  line write data.
- mem_rdata  in  WORD_W*WORDS_PER_LINE  line read data; sampled when mem_ready is high.
- mem_ready  in  1  transaction complete; meaningful only while mem_req is high.

## Operation
- Derived widths:
  - OFF_W = clog2(WORDS_PER_LINE)
  - IDX_W = clog2(LINES)
  - TAG_W = ADDR_W-IDX_W-OFF_W, must be ≥1
- Address split is tag | index | offset, MSB to LSB.
- Word k of a line occupies line bits [k*WORD_W +: WORD_W].
- Per-line storage: valid, dirty, tag, data.
- States and transitions:
  - IDLE:
    - flush_req has priority over cpu_req.
    - flush_req → FLUSH with ptr = 0.
    - cpu_req → latch addr/we/wdata, then LOOKUP.
  - LOOKUP (hit = valid and tag match):
    - Hit: cpu_ready = 1. A read drives the word. A write updates the word, sets dirty, and echoes the written word on cpu_rdata. Next state IDLE.
    - Miss, valid and dirty: WRITEBACK.
    - Miss otherwise: ALLOCATE.
  - WRITEBACK:
    - mem_we = 1, mem_addr = {stored tag, index}, mem_wdata = line.
    - On mem_ready: clear dirty, then ALLOCATE.
  - ALLOCATE:
    - mem_we = 0, mem_addr = {latched tag, index}.
    - On mem_ready: load mem_rdata, set tag, valid = 1, dirty = 0, then LOOKUP. LOOKUP now hits and performs any write.
  - FLUSH:
    - Per index: if valid and dirty, perform a write transaction, then clear dirty. Otherwise advance in one cycle. valid bits are untouched.
    - After index LINES-1: flush_done pulse, then IDLE.
- cpu_req, flush_req and CPU inputs are ignored outside IDLE. CPU inputs are not re-sampled during a miss.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE.
  - All valid and dirty bits 0.
  - cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata, flush_done all 0.
  - ptr 0.
  - Data and tag arrays are not reset.
- Hit: request sampled at edge n; cpu_ready high during cycle n+1.
- Clean miss with memory latency L (mem_ready high L cycles after mem_req rises): cpu_ready follows 2 cycles after mem_ready.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are stable from assertion until the edge where mem_ready is sampled high.
  - mem_req drops for exactly one cycle after every accepted transaction, including between WRITEBACK and ALLOCATE.
- mem_ready while mem_req is low is ignored.
- All-clean flush: flush_done is high LINES cycles after acceptance.
- rst mid-transaction takes effect immediately:
  - mem_req and cpu_ready go low asynchronously.
  - Lines being written back are lost; this is intended.
- cpu_req held high after cpu_ready is treated as a new request.

## Structure
- Package wb_cache_pkg:
  - state enum (IDLE, LOOKUP, WRITEBACK, ALLOCATE, FLUSH).
  - clog2-based width helper functions.
- Sub-module wb_cache_store: tag/valid/dirty/data arrays.
  - Asynchronous read.
  - Synchronous write with word-select and line-fill ports.
  - Asynchronous clear of valid/dirty.
- The top level contains the FSM, the request latch and the flush pointer.

## Test plan
All scenarios use default parameters.
- Read, then read other word of line:
  - Stimulus: reset; read addr 50; mem_rdata = {10'd7,10'd5}, mem_ready after 3 cycles.
  - Response: one read with mem_addr = 25; cpu_rdata = 5. Then read 51: no mem_req, cpu_rdata = 7, cpu_ready at n+1.
- Write miss then read hit:
  - Stimulus: write 300 to addr 84 (index 10, tag 2).
  - Response: allocate mem_addr = 42 and cpu_ready. Reading 84 returns 300. No mem write issued.
- Dirty eviction:
  - Stimulus: after the previous scenario, read addr 116 (same index, tag 3).
  - Response: write at mem_addr = 42 with low word 300, one idle cycle, read at mem_addr = 58, then cpu_ready.
- Flush:
  - Stimulus: lines 3 and 9 dirty; flush_req.
  - Response: exactly two writes, index 3 before 9, then one flush_done. A second flush issues no writes; flush_done after 16 cycles.
- Memory stall:
  - Stimulus: mem_ready held off for 20 cycles.
  - Response: mem_req/addr/wdata stable throughout; no cpu_ready.
- Reset during WRITEBACK:
  - Stimulus: assert rst while mem_req is high.
  - Response: mem_req low immediately. A subsequent read of 84 misses.
